wb_arb: RTL and testbench
=========================

# wb_arb

Writeback arbiter that owns the register file's single write port (`we`, `w_addr`, `w_data`). It merges two producers into one registered write per cycle:

- the single-cycle ALU result path, which has priority;
- a long-latency multiply/divide result path, buffered in a small FIFO.

It also keeps a scoreboard of destination registers with long-latency results still in flight, which the decode stage uses for stall decisions.

## Interface
Parameters:
- `MD_DEPTH`, default 2: number of long-latency result FIFO entries (power of two, ≥2).
- `STARVE_LIM`, default 4: maximum consecutive ALU wins while the FIFO is non-empty.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_waddr` in 5: ALU destination register.
- `alu_wdata` in 32: ALU result.
- `md_valid` in 1: mul/div result present.
- `md_ready` out 1: FIFO can accept.
- `md_waddr` in 5: mul/div destination register.
- `md_wdata` in 32: mul/div result.
- `iss_valid` in 1: long-latency op issued this cycle.
- `iss_waddr` in 5: its destination register.
- `busy` out 32: per-register pending flag; bit 0 is always 0.
- `rf_we` out 1: to register file `we`.
- `rf_waddr` out 5: to register file `w_addr`.
- `rf_wdata` out 32: to register file `w_data`.

## Operation
- Reset values:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0.
  - FIFO empty; starvation counter `scnt`=0.
  - `alu_ready`=1, `md_ready`=1 in the first cycle after `rst` deasserts.
- Arbitration, evaluated each cycle in priority order:
  1. ALU wins if `alu_valid && alu_ready`.
  2. Otherwise pop the FIFO head if the FIFO is non-empty.
  3. Otherwise `rf_we`=0 next cycle.
- `alu_ready` = (`scnt` != `STARVE_LIM`).
  - While `alu_ready`=0, upstream holds its ALU data stable.
  - The FIFO is guaranteed to pop that cycle.
- Starvation counter `scnt`:
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears to 0 on any FIFO pop, and whenever the FIFO is empty.
- FIFO push: `md_ready` = FIFO not full. A push occurs when `md_valid && md_ready`.
  - With a full FIFO, a same-cycle pop does not enable a push.
  - Simultaneous push and pop on a non-full FIFO are both performed.
- Zero register:
  - An ALU result with `alu_waddr`=0 is accepted but produces `rf_we`=0.
  - An md result with `md_waddr`=0 is accepted (handshake completes) and dropped, never entering the FIFO.
- Scoreboard:
  - `iss_valid` with `iss_waddr`≠0 sets `busy[iss_waddr]` at the next edge.
  - `busy[r]` clears at the edge ending the cycle in which `rf_we`=1, `rf_waddr`=r, and the write came from the FIFO. The register file captures the data on that same edge, so a reader never sees `busy`=0 with stale contents.
  - Set and clear of the same register on the same edge: set wins.
  - ALU writes never touch `busy`.
  - Upstream must not issue a long-latency op to an already-busy register. If it does, the bit clears on the first matching pop.
- Reset asserted mid-operation: FIFO contents and `busy` are discarded, and `rf_we` is forced to 0 at that edge.

## Timing
- `rf_*` outputs are registered: a write decided in cycle N drives `rf_we` in cycle N+1 and lands in the register file at the end of N+1.
- ALU path latency: 1 cycle (accept N → `rf_we` N+1).
- md path minimum latency: push N → pop decision N+1 → `rf_we` N+2; `busy` low from N+3.
- `md_ready` and `alu_ready` depend only on registered state, with no combinational path from `*_valid`.
- Throughput: one register write per cycle. The FIFO is guaranteed to drain at least one entry every `STARVE_LIM`+1 cycles.

## Configuration
- `WB_SCOREBOARD_EN` defined: the scoreboard is built as described.
- `WB_SCOREBOARD_EN` undefined:
  - `busy` is tied to 0.
  - `iss_valid`/`iss_waddr` are ignored.
  - No scoreboard flops are present.
  - The decode stage then relies on a fixed-latency stall.

## Structure
- Shared package `wb_pkg`:
  - `REG_AW`=5, `DATA_W`=32.
  - `md_entry_t` typedef {waddr, wdata}.
  - `STARVE_LIM` default constant.
- Sub-module `wb_fifo`: synchronous FIFO of `md_entry_t`, depth `MD_DEPTH`, with push/pop/full/empty, pointer wrap-around, and synchronous active-high reset.
- The arbitration, starvation counter and scoreboard live in `wb_arb`.

## Test plan
- **ALU only:** `alu_valid`=1, `alu_waddr`=5, `alu_wdata`=0xDEADBEEF → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; `alu_waddr`=0 → `rf_we`=0.
- **md plus scoreboard:** `iss_valid`, `iss_waddr`=9 → `busy[9]`=1. Then md push (9, 0x12345678) with the ALU idle → `rf_we` two cycles after the push with data 0x12345678; `busy[9]`=0 one cycle later.
- **Full FIFO:** push 2 entries with the ALU valid every cycle → `md_ready`=0. Third `md_valid` held → accepted only after a pop frees a slot; entries are written in FIFO order.
- **Starvation:** FIFO holds 1 entry and `alu_valid`=1 continuously → `alu_ready`=0 exactly on the 5th cycle and the FIFO entry is written then. The held ALU data is written the following cycle.
- **Simultaneous set/clear:** a pop to r7 and `iss_valid` r7 in the same cycle → `busy[7]` remains 1.
- **Reset mid-flight:** 2 FIFO entries and `busy`≠0, assert `rst` for one cycle → `rf_we`=0, `busy`=0, FIFO empty, and no stale writes afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its long-latency result FIFO.
package wb_pkg;

    localparam int REG_AW         = 5;
    localparam int DATA_W         = 32;
    localparam int STARVE_LIM_DEF = 4;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } md_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of md_entry_t; pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  md_entry_t din,
    output md_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    md_entry_t   mem_q [DEPTH];
    md_entry_t   mem_d [DEPTH];
    logic        push_ok, pop_ok;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rp_q[AW-1:0]];

    always_comb begin
        wp_d  = push_ok ? wp_q + 1'b1 : wp_q;
        rp_d  = pop_ok  ? rp_q + 1'b1 : rp_q;
        mem_d = mem_q;
        if (push_ok) mem_d[wp_q[AW-1:0]] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: ALU results take priority, mul/div results drain from a FIFO under a
// starvation limit. Define WB_SCOREBOARD_EN to build the in-flight destination scoreboard.
module wb_arb
    import wb_pkg::*;
#(
    parameter int MD_DEPTH   = 2,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_waddr,
    input  logic [DATA_W-1:0] md_wdata,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_waddr,
    output logic [31:0]       busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0]     scnt_q, scnt_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              fifo_full, fifo_empty, alu_win, pop, push;
    md_entry_t         fifo_in, head;

    assign alu_ready = (scnt_q != SW'(STARVE_LIM));
    assign md_ready  = !fifo_full;
    assign alu_win   = alu_valid && alu_ready;
    assign pop       = !alu_win && !fifo_empty;
    // Results to r0 complete the handshake but never occupy a FIFO slot.
    assign push      = md_valid && md_ready && (md_waddr != '0);
    assign fifo_in   = '{waddr: md_waddr, wdata: md_wdata};

    wb_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        scnt_d     = scnt_q;
        if (alu_win) begin
            rf_we_d    = (alu_waddr != '0);
            rf_waddr_d = alu_waddr;
            rf_wdata_d = alu_wdata;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head.waddr;
            rf_wdata_d = head.wdata;
        end
        if (pop || fifo_empty) scnt_d = '0;
        else if (alu_win)      scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            scnt_q     <= scnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic        rf_md_q, rf_md_d;

    // Clear on the edge the register file captures a FIFO write; a same-edge issue wins.
    always_comb begin
        rf_md_d = pop;
        busy_d  = busy_q;
        if (rf_we_q && rf_md_q)              busy_d[rf_waddr_q] = 1'b0;
        if (iss_valid && iss_waddr != '0)    busy_d[iss_waddr]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            rf_md_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rf_md_q <= rf_md_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_waddr};
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Directed table-driven bench for wb_arb (MD_DEPTH=2, STARVE_LIM=4) plus reset sequences.
module tb_wb_arb;
    import wb_pkg::*;

`ifdef WB_SCOREBOARD_EN
    localparam logic [31:0] SBM = '1;
`else
    localparam logic [31:0] SBM = '0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, md_valid, md_ready, iss_valid, rf_we;
    logic [4:0]  alu_waddr, md_waddr, iss_waddr, rf_waddr;
    logic [31:0] alu_wdata, md_wdata, busy, rf_wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arb #(.MD_DEPTH(2), .STARVE_LIM(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_waddr  (md_waddr),
        .md_wdata  (md_wdata),
        .iss_valid (iss_valid),
        .iss_waddr (iss_waddr),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ia;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] eb;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                                input int mv, input int ma, input logic [31:0] md,
                                input int iv, input int ia,
                                input int ear, input int emr,
                                input int ewe, input int ewa, input logic [31:0] ewd,
                                input logic [31:0] eb);
        vec_t r;
        r.av = 1'(av);   r.aa = 5'(aa);   r.ad = ad;
        r.mv = 1'(mv);   r.ma = 5'(ma);   r.md = md;
        r.iv = 1'(iv);   r.ia = 5'(ia);
        r.ear = 1'(ear); r.emr = 1'(emr);
        r.ewe = 1'(ewe); r.ewa = 5'(ewa); r.ewd = ewd;
        r.eb = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic iv, input logic [4:0] ia);
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        md_valid  = mv; md_waddr  = ma; md_wdata  = md;
        iss_valid = iv; iss_waddr = ia;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        av aa ad            mv ma md            iv ia ar mr we wa wd            busy
        tv[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h0);
        tv[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 1, 1, 1, 5, 32'hDEADBEEF, 32'h0);
        tv[2]  = mk(1, 0, 32'h11111111, 0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h0);
        tv[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 1, 1, 0, 0, 32'h0,        32'h200);
        tv[4]  = mk(0, 0, 32'h0,        1, 9, 32'h12345678, 0, 0, 1, 1, 0, 0, 32'h0,        32'h200);
        tv[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 1, 9, 32'h12345678, 32'h200);
        tv[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h0);
        // full FIFO: two pushes under ALU traffic, third held until a slot frees
        tv[7]  = mk(1, 1, 32'hA1,       1, 3, 32'h33,       0, 0, 1, 1, 1, 1, 32'hA1,       32'h0);
        tv[8]  = mk(1, 2, 32'hA2,       1, 4, 32'h44,       0, 0, 1, 1, 1, 2, 32'hA2,       32'h0);
        tv[9]  = mk(1, 1, 32'hA3,       1, 5, 32'h55,       0, 0, 1, 0, 1, 1, 32'hA3,       32'h0);
        tv[10] = mk(0, 0, 32'h0,        1, 5, 32'h55,       0, 0, 1, 0, 1, 3, 32'h33,       32'h0);
        tv[11] = mk(0, 0, 32'h0,        1, 5, 32'h55,       0, 0, 1, 1, 1, 4, 32'h44,       32'h0);
        tv[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 1, 5, 32'h55,       32'h0);
        tv[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h0);
        // starvation: one queued entry against continuous ALU traffic
        tv[14] = mk(1, 10, 32'hB0,      1, 6, 32'h66,       0, 0, 1, 1, 1, 10, 32'hB0,      32'h0);
        tv[15] = mk(1, 11, 32'hB1,      0, 0, 32'h0,        0, 0, 1, 1, 1, 11, 32'hB1,      32'h0);
        tv[16] = mk(1, 12, 32'hB2,      0, 0, 32'h0,        0, 0, 1, 1, 1, 12, 32'hB2,      32'h0);
        tv[17] = mk(1, 13, 32'hB3,      0, 0, 32'h0,        0, 0, 1, 1, 1, 13, 32'hB3,      32'h0);
        tv[18] = mk(1, 14, 32'hB4,      0, 0, 32'h0,        0, 0, 1, 1, 1, 14, 32'hB4,      32'h0);
        tv[19] = mk(1, 15, 32'hB5,      0, 0, 32'h0,        0, 0, 0, 1, 1, 6, 32'h66,       32'h0);
        tv[20] = mk(1, 15, 32'hB5,      0, 0, 32'h0,        0, 0, 1, 1, 1, 15, 32'hB5,      32'h0);
        tv[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h0);
        // set and clear of r7 on the same edge
        tv[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 1, 1, 0, 0, 32'h0,        32'h80);
        tv[23] = mk(0, 0, 32'h0,        1, 7, 32'h77,       0, 0, 1, 1, 0, 0, 32'h0,        32'h80);
        tv[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 1, 7, 32'h77,       32'h80);
        tv[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 1, 1, 0, 0, 32'h0,        32'h80);
        tv[26] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h80);
        // r0 issue ignored; r0 md result accepted and dropped
        tv[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 1, 0, 0, 32'h0,        32'h80);
        tv[28] = mk(0, 0, 32'h0,        1, 0, 32'hDEAD,     0, 0, 1, 1, 0, 0, 32'h0,        32'h80);
        tv[29] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,        32'h80);

        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rf_we",    {31'b0, rf_we},    32'h0);
        chk("reset_rf_waddr", {27'b0, rf_waddr}, 32'h0);
        chk("reset_rf_wdata", rf_wdata,          32'h0);
        chk("reset_busy",     busy,              32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].av, tv[i].aa, tv[i].ad, tv[i].mv, tv[i].ma, tv[i].md, tv[i].iv, tv[i].ia);
            chk($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, tv[i].ear});
            chk($sformatf("v%0d_md_ready", i),  {31'b0, md_ready},  {31'b0, tv[i].emr});
            tick();
            chk($sformatf("v%0d_rf_we", i), {31'b0, rf_we}, {31'b0, tv[i].ewe});
            if (tv[i].ewe) begin
                chk($sformatf("v%0d_rf_waddr", i), {27'b0, rf_waddr}, {27'b0, tv[i].ewa});
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tv[i].ewd);
            end
            chk($sformatf("v%0d_busy", i), busy, tv[i].eb & SBM);
        end

        // reset mid-flight: two queued entries and r7/r8 pending
        drive(1'b1, 5'd1, 32'hC1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd8);
        tick();
        chk("mf_busy_set", busy, 32'h180 & SBM);
        drive(1'b1, 5'd2, 32'hC2, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        tick();
        chk("mf_md_full", {31'b0, md_ready}, 32'h0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mf_rst_rf_we",  {31'b0, rf_we},     32'h0);
        chk("mf_rst_busy",   busy,               32'h0);
        chk("mf_rst_md_rdy", {31'b0, md_ready},  32'h1);
        chk("mf_rst_alu_rdy",{31'b0, alu_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mf_no_stale%0d", k), {31'b0, rf_we}, 32'h0);
        end

        // reset wins over a live ALU result on the same edge
        drive(1'b1, 5'd3, 32'hC3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("rst_over_alu", {31'b0, rf_we}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
